mfp_ahb_timer_slave: RTL and testbench
======================================

Name: mfp_ahb_timer_slave

Overview:
- AHB-Lite slave holding a 32-bit down-counting timer with prescaler, auto-reload and level interrupt.
- Hangs directly below the AHB-Lite matrix as a new slave port.
- Gets its own HSEL from the decoder; returns HRDATA/HRESP to the response mux, which muxes on the delayed HSEL in the data phase, and HREADY to the matrix HREADY OR.
- Zero-wait-state, always-OKAY device.

Parameters:
PRESCALE_W, 16, width of prescaler divide register and prescaler counter
LOAD_RESET, 32'h0000_0000, reset value of the LOAD register

Ports:
HCLK  input  1  bus clock, all state on rising edge
HRESET  input  1  asynchronous, active-high reset
HADDR  input  32  address; only HADDR[4:2] decoded
HBURST  input  3  ignored
HMASTLOCK  input  1  ignored
HPROT  input  4  ignored
HSEL  input  1  slave select from decoder
HSIZE  input  3  transfer size; only 3'b010 writes take effect
HTRANS  input  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ
HWDATA  input  32  write data, data phase
HWRITE  input  1  1=write
HRDATA  output  32  read data, data phase
HREADY  output  1  constant 1 (no wait states)
HRESP  output  1  constant 0 (OKAY)
SI_Endian  input  1  ignored; registers are word-only
IRQ  output  1  timer interrupt, registered

Behaviour:
- Reset (HRESET=1, async): CTRL=0, LOAD=LOAD_RESET, COUNT=0, STATUS=0, PRESCALE=0, prescaler counter=0, IRQ=0, data-phase flags cleared. HRDATA=0, HREADY=1, HRESP=0 from reset onward.
- Address phase: valid when HSEL & HTRANS[1]. On that edge the block registers offset HADDR[4:2], HWRITE, a size-ok flag (HSIZE==3'b010) and a valid flag. With no valid transfer, the valid flag clears.
- Register map (offset = HADDR[4:2]):
  - 0 CTRL: [0] EN, [1] RELOAD, [2] IE; other bits read 0.
  - 1 LOAD.
  - 2 COUNT.
  - 3 STATUS: [0] EXPIRED; write-1-to-clear.
  - 4 PRESCALE: [PRESCALE_W-1:0].
  - 5-7: read 0, writes ignored.
- Write: commits on the edge ending the data phase, using HWDATA, when the registered valid, write and size-ok flags are all set. Non-word writes are silently dropped; HRESP stays 0.
- Read: HRDATA is combinational in the data phase from the registered offset. It is 0 when no read data phase is in progress.
  - Read latency: data valid in the cycle after the address phase.
  - Write followed by read of the same register, back-to-back: the read returns the new value.
- Prescaler:
  - When EN=1, the prescaler counter counts 0..PRESCALE, wraps to 0, and issues one tick on the wrap cycle. PRESCALE=0 gives a tick every cycle.
  - When EN=0, the prescaler counter is held at 0.
  - A CTRL write that sets EN 0->1 clears the prescaler counter.
  - A PRESCALE write also clears the prescaler counter.
- Counter, on tick:
  - If COUNT!=0: COUNT-1.
  - If COUNT==0: EXPIRED<=1; then if RELOAD=1, COUNT<=LOAD; else EN<=0 and COUNT stays 0.
  - Period with RELOAD=1 is (LOAD+1)*(PRESCALE+1) cycles.
- IRQ: registered (EXPIRED & IE), so it follows by one cycle. It is level and stays high until STATUS is cleared or IE is cleared.
- Simultaneous events:
  - Bus write to COUNT on a tick edge: the write wins and the tick's decrement or reload is lost.
  - STATUS W1C on the edge an expiry occurs: set wins, EXPIRED stays 1.
  - CTRL write clearing EN on a tick edge: the tick's COUNT update still applies, then the counter halts.
  - Hardware EN<=0 (one-shot expiry) on the same edge as a bus CTRL write: the bus write wins.
- Reset mid-transfer: the pending data phase is abandoned and no write commits.
- Wrap-around: COUNT never decrements below 0. Writing LOAD has no effect on COUNT until the next reload.

Test Plan:
- Reset check: assert HRESET mid write data phase -> CTRL reads 0; HREADY=1, HRESP=0, IRQ=0 throughout.
- Register access: write LOAD=32'hDEAD_BEEF at offset 1, then read back-to-back -> HRDATA=32'hDEAD_BEEF in the read data phase. Halfword write (HSIZE=1) of 32'h1234 -> LOAD unchanged. Read offset 6 -> 0.
- Periodic reload: PRESCALE=3, LOAD=4, COUNT=4, CTRL=3'b111 -> EXPIRED every 20 cycles; IRQ rises 1 cycle after EXPIRED. STATUS write 1 -> IRQ falls next cycle; it re-asserts 20 cycles after the previous expiry.
- One-shot: PRESCALE=0, COUNT=2, CTRL=3'b001 -> EXPIRED set 3 cycles after enable; CTRL.EN reads 0; COUNT holds 0; no IRQ since IE=0.
- Collisions: write COUNT=100 on a tick edge -> COUNT reads 100 next cycle, not 99. W1C to STATUS on an expiry edge -> EXPIRED remains 1.
- Re-enable: clear EN mid-prescale (counter=2 of PRESCALE=5), then set EN -> first tick arrives 6 cycles after the enabling write commits.

Source files
------------

// File: rtl/mfp_ahb_timer_slave_if.sv
// AHB-Lite slave-port signal bundle for the timer slave.
// Signal names mirror the AHB-Lite matrix port names.
interface mfp_ahb_timer_slave_if;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic        HSEL;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        SI_Endian;

  modport master (
    output HADDR, HBURST, HMASTLOCK, HPROT, HSEL, HSIZE, HTRANS, HWDATA, HWRITE, SI_Endian,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HBURST, HMASTLOCK, HPROT, HSEL, HSIZE, HTRANS, HWDATA, HWRITE, SI_Endian,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/mfp_ahb_timer_slave.sv
// Zero-wait-state AHB-Lite slave: 32-bit down-counting timer with prescaler,
// auto-reload and a registered level interrupt.
module mfp_ahb_timer_slave #(
  parameter int unsigned PRESCALE_W = 16,
  parameter logic [31:0] LOAD_RESET = 32'h0000_0000
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  mfp_ahb_timer_slave_if.slave  ahb,
  output logic                  IRQ
);

  localparam logic [2:0] OffCtrl     = 3'd0;
  localparam logic [2:0] OffLoad     = 3'd1;
  localparam logic [2:0] OffCount    = 3'd2;
  localparam logic [2:0] OffStatus   = 3'd3;
  localparam logic [2:0] OffPrescale = 3'd4;

  // Data-phase state captured at the end of the address phase
  logic [2:0] addr_q;
  logic       write_q, size_ok_q, valid_q;

  logic                  en_q, en_d;
  logic                  reload_q, reload_d;
  logic                  ie_q, ie_d;
  logic [31:0]           load_q, load_d;
  logic [31:0]           count_q, count_d;
  logic                  expired_q, expired_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  irq_q;

  logic        wr_en, wr_ctrl, wr_load, wr_count, wr_status, wr_prescale;
  logic        tick, expire;
  logic [31:0] rdata;

  logic unused_bits;
  assign unused_bits = ^{ahb.HADDR[31:5], ahb.HADDR[1:0], ahb.HBURST, ahb.HMASTLOCK,
                         ahb.HPROT, ahb.SI_Endian};

  always_comb begin
    wr_en       = valid_q & write_q & size_ok_q;
    wr_ctrl     = wr_en & (addr_q == OffCtrl);
    wr_load     = wr_en & (addr_q == OffLoad);
    wr_count    = wr_en & (addr_q == OffCount);
    wr_status   = wr_en & (addr_q == OffStatus);
    wr_prescale = wr_en & (addr_q == OffPrescale);
    tick        = en_q & (pre_cnt_q == prescale_q);
    expire      = tick & (count_q == '0);
  end

  always_comb begin
    en_d       = en_q;
    reload_d   = reload_q;
    ie_d       = ie_q;
    if (expire && !reload_q) en_d = 1'b0;
    // Bus write overrides the one-shot auto-disable on the same edge
    if (wr_ctrl) {ie_d, reload_d, en_d} = ahb.HWDATA[2:0];

    load_d = wr_load ? ahb.HWDATA : load_q;

    count_d = count_q;
    if (tick) begin
      if (count_q != '0) count_d = count_q - 1'b1;
      else if (reload_q) count_d = load_q;
    end
    if (wr_count) count_d = ahb.HWDATA;

    // W1C first so a coincident expiry still sets the flag
    expired_d = expired_q;
    if (wr_status && ahb.HWDATA[0]) expired_d = 1'b0;
    if (expire) expired_d = 1'b1;

    prescale_d = wr_prescale ? ahb.HWDATA[PRESCALE_W-1:0] : prescale_q;

    if (wr_prescale || (wr_ctrl && !en_q && ahb.HWDATA[0]) || !en_q || tick) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_ok_q  <= 1'b0;
      valid_q    <= 1'b0;
      en_q       <= 1'b0;
      reload_q   <= 1'b0;
      ie_q       <= 1'b0;
      load_q     <= LOAD_RESET;
      count_q    <= '0;
      expired_q  <= 1'b0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      addr_q     <= ahb.HADDR[4:2];
      write_q    <= ahb.HWRITE;
      size_ok_q  <= (ahb.HSIZE == 3'b010);
      valid_q    <= ahb.HSEL & ahb.HTRANS[1];
      en_q       <= en_d;
      reload_q   <= reload_d;
      ie_q       <= ie_d;
      load_q     <= load_d;
      count_q    <= count_d;
      expired_q  <= expired_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      irq_q      <= expired_q & ie_q;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr_q)
      OffCtrl:     rdata[2:0] = {ie_q, reload_q, en_q};
      OffLoad:     rdata = load_q;
      OffCount:    rdata = count_q;
      OffStatus:   rdata[0] = expired_q;
      OffPrescale: rdata[PRESCALE_W-1:0] = prescale_q;
      default:     rdata = '0;
    endcase
  end

  assign ahb.HRDATA = (valid_q && !write_q) ? rdata : '0;
  assign ahb.HREADY = 1'b1;
  assign ahb.HRESP  = 1'b0;
  assign IRQ        = irq_q;

endmodule

// File: tb/tb_mfp_ahb_timer_slave.sv
// Directed bench for mfp_ahb_timer_slave: register access, timing of the
// prescaler/counter/IRQ and the simultaneous-event rules.
module tb_mfp_ahb_timer_slave;

  localparam logic [2:0] OffCtrl     = 3'd0;
  localparam logic [2:0] OffLoad     = 3'd1;
  localparam logic [2:0] OffCount    = 3'd2;
  localparam logic [2:0] OffStatus   = 3'd3;
  localparam logic [2:0] OffPrescale = 3'd4;
  localparam logic [2:0] SzWord      = 3'b010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  mfp_ahb_timer_slave_if bus ();

  mfp_ahb_timer_slave #(
    .PRESCALE_W (16),
    .LOAD_RESET (32'h0000_0000)
  ) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .ahb    (bus),
    .IRQ    (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = SzWord;
    bus.HADDR  = '0;
  endtask

  task automatic addr_phase(input logic [2:0] off, input logic wr, input logic [2:0] size);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = {27'h0, off, 2'b00};
    bus.HWRITE = wr;
    bus.HSIZE  = size;
  endtask

  // Entered and left #1 after a rising edge; returns just after the commit edge
  task automatic ahb_write(input logic [2:0] off, input logic [31:0] data,
                           input logic [2:0] size);
    addr_phase(off, 1'b1, size);
    @(posedge clk); #1;
    bus_idle();
    bus.HWDATA = data;
    @(posedge clk); #1;
  endtask

  task automatic ahb_read(input logic [2:0] off, output logic [31:0] data);
    addr_phase(off, 1'b0, SzWord);
    @(posedge clk); #1;
    data = bus.HRDATA;
    bus_idle();
  endtask

  // Write then read the same offset with the read address phase in the write data phase
  task automatic wr_rd_b2b(input logic [2:0] off, input logic [31:0] data,
                           output logic [31:0] rdata);
    addr_phase(off, 1'b1, SzWord);
    @(posedge clk); #1;
    bus.HWDATA = data;
    addr_phase(off, 1'b0, SzWord);
    @(posedge clk); #1;
    rdata = bus.HRDATA;
    bus_idle();
  endtask

  task automatic wait_irq_high(input string tag, input int limit, output int t);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (irq) break;
    end
    t = cyc;
    check_eq(tag, {31'b0, irq}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int c0, t1, t2;
    bus_idle();
    bus.HWDATA    = '0;
    bus.HBURST    = '0;
    bus.HMASTLOCK = 1'b0;
    bus.HPROT     = '0;
    bus.SI_Endian = 1'b0;

    // Reset
    @(posedge clk); #1;
    check_eq("rst_hrdata", bus.HRDATA, 32'h0);
    check_eq("rst_hready", {31'b0, bus.HREADY}, 32'd1);
    check_eq("rst_hresp", {31'b0, bus.HRESP}, 32'd0);
    check_eq("rst_irq", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    ahb_read(OffCtrl, rd);     check_eq("rst_ctrl", rd, 32'h0);
    ahb_read(OffLoad, rd);     check_eq("rst_load", rd, 32'h0);
    ahb_read(OffCount, rd);    check_eq("rst_count", rd, 32'h0);
    ahb_read(OffStatus, rd);   check_eq("rst_status", rd, 32'h0);
    ahb_read(OffPrescale, rd); check_eq("rst_prescale", rd, 32'h0);

    // Reset during a write data phase abandons the write
    addr_phase(OffCtrl, 1'b1, SzWord);
    @(posedge clk); #1;
    bus_idle();
    bus.HWDATA = 32'h7;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_hready", {31'b0, bus.HREADY}, 32'd1);
    check_eq("midrst_irq", {31'b0, irq}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    ahb_read(OffCtrl, rd);     check_eq("midrst_ctrl", rd, 32'h0);

    // Register access
    wr_rd_b2b(OffLoad, 32'hDEAD_BEEF, rd);  check_eq("b2b_load", rd, 32'hDEAD_BEEF);
    ahb_write(OffLoad, 32'h0000_1234, 3'b001);
    check_eq("idle_hrdata", bus.HRDATA, 32'h0);
    ahb_read(OffLoad, rd);     check_eq("half_load", rd, 32'hDEAD_BEEF);
    ahb_write(3'd6, 32'hFFFF_FFFF, SzWord);
    ahb_read(3'd6, rd);        check_eq("off6", rd, 32'h0);
    ahb_write(OffPrescale, 32'h0001_2345, SzWord);
    ahb_read(OffPrescale, rd); check_eq("prescale_mask", rd, 32'h0000_2345);
    check_eq("hresp_ok", {31'b0, bus.HRESP}, 32'd0);

    // Periodic reload: period (4+1)*(3+1) = 20
    ahb_write(OffPrescale, 32'd3, SzWord);
    ahb_write(OffLoad, 32'd4, SzWord);
    ahb_write(OffCount, 32'd4, SzWord);
    ahb_write(OffCtrl, 32'h7, SzWord);
    c0 = cyc;
    wait_irq_high("per_irq1", 40, t1);
    check_eq("per_irq1_delay", t1 - c0, 32'd21);
    ahb_write(OffStatus, 32'h1, SzWord);
    check_eq("per_irq_hold", {31'b0, irq}, 32'd1);
    @(posedge clk); #1;
    check_eq("per_irq_clear", {31'b0, irq}, 32'd0);
    wait_irq_high("per_irq2", 40, t2);
    check_eq("per_period", t2 - t1, 32'd20);
    ahb_read(OffStatus, rd);   check_eq("per_status", rd, 32'h1);
    ahb_write(OffCtrl, 32'h0, SzWord);
    ahb_write(OffStatus, 32'h1, SzWord);
    check_eq("per_irq_off", {31'b0, irq}, 32'd0);

    // One-shot: expires 3 ticks after enable, then disables itself
    ahb_write(OffPrescale, 32'd0, SzWord);
    ahb_write(OffCount, 32'd2, SzWord);
    ahb_write(OffCtrl, 32'h1, SzWord);
    ahb_read(OffStatus, rd);   check_eq("os_status1", rd, 32'h0);
    ahb_read(OffStatus, rd);   check_eq("os_status2", rd, 32'h0);
    ahb_read(OffStatus, rd);   check_eq("os_status3", rd, 32'h1);
    ahb_read(OffCtrl, rd);     check_eq("os_ctrl", rd, 32'h0);
    ahb_read(OffCount, rd);    check_eq("os_count", rd, 32'h0);
    check_eq("os_irq", {31'b0, irq}, 32'd0);

    // Bus COUNT write on a tick edge wins
    ahb_write(OffStatus, 32'h1, SzWord);
    ahb_write(OffCount, 32'd1000, SzWord);
    ahb_write(OffCtrl, 32'h3, SzWord);
    wr_rd_b2b(OffCount, 32'd100, rd);       check_eq("col_count", rd, 32'd100);
    ahb_write(OffCtrl, 32'h0, SzWord);

    // W1C on the expiry edge: set wins
    ahb_write(OffLoad, 32'd50, SzWord);
    ahb_write(OffCount, 32'd1, SzWord);
    ahb_write(OffStatus, 32'h1, SzWord);
    ahb_write(OffCtrl, 32'h3, SzWord);
    ahb_write(OffStatus, 32'h1, SzWord);
    ahb_read(OffStatus, rd);   check_eq("col_w1c", rd, 32'h1);
    ahb_read(OffCount, rd);    check_eq("col_reload", rd, 32'd48);
    ahb_write(OffCtrl, 32'h0, SzWord);

    // Re-enable restarts the prescaler: first tick 6 cycles after commit
    ahb_write(OffStatus, 32'h1, SzWord);
    ahb_write(OffPrescale, 32'd5, SzWord);
    ahb_write(OffCount, 32'd10, SzWord);
    ahb_write(OffCtrl, 32'h1, SzWord);
    @(posedge clk); #1;
    ahb_write(OffCtrl, 32'h0, SzWord);
    ahb_write(OffCtrl, 32'h1, SzWord);
    for (int k = 1; k <= 6; k++) begin
      ahb_read(OffCount, rd);
      check_eq($sformatf("reen_count_%0d", k), rd, (k < 6) ? 32'd10 : 32'd9);
    end
    ahb_write(OffCtrl, 32'h0, SzWord);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
